// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: key debounce, 100 Hz tick divider and run/pause/lap/clear sequencer (lap path built only with STOPWATCH_LAP_EN)
module stopwatch_ctrl #(
  parameter int CLK_HZ    = 50000000,
  parameter int TICK_HZ   = 100,
  parameter int DB_CYCLES = 500000
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       key_start,
  input  logic       key_clr,
  input  logic       key_lap,
  input  logic       sw_en,
  output logic       tick,
  output logic       pause,
  output logic       clr,
  output logic       lap_hold,
  output logic [1:0] state
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DW  = $clog2(DIV);
  localparam int CW  = $clog2(DB_CYCLES + 1);
`ifdef STOPWATCH_LAP_EN
  localparam int NK = 3;
  logic [NK-1:0] keys;
  assign keys = {key_lap, key_clr, key_start};
`else
  localparam int NK = 2;
  logic [NK-1:0] keys;
  logic          unused;
  assign keys   = {key_clr, key_start};
  assign unused = key_lap;
`endif
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSED = 2'b10, LAP = 2'b11} state_t;
  state_t        st, nxt;
  logic [NK-1:0] press;
  logic [DW-1:0] div_cnt;
  logic          ev_start, ev_clr, ev_lap;
  for (genvar k = 0; k < NK; k++) begin : g_key
    logic          s1, s2, db, prev, armed;
    logic [CW-1:0] cnt;
    // synchronise, debounce and arm one key; arming waits for a released level so a key held through reset gives no event
    always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
        s1    <= 1'b0;
        s2    <= 1'b0;
        db    <= 1'b1;
        prev  <= 1'b1;
        armed <= 1'b0;
        cnt   <= '0;
      end else begin
        s1    <= keys[k];
        s2    <= s1;
        prev  <= db;
        armed <= armed | s2;
        cnt   <= (s2 == db || cnt == CW'(DB_CYCLES - 1)) ? '0 : cnt + CW'(1);
        if (s2 != db && cnt == CW'(DB_CYCLES - 1)) db <= s2;
      end
    end
    assign press[k] = armed & prev & ~db;
  end
  assign tick     = sw_en && div_cnt == DW'(DIV - 1);
  assign ev_start = press[0] & sw_en;
  assign ev_clr   = press[1] & sw_en;
  assign state    = st;
  // free-running tick divider, frozen while the master enable is off
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) div_cnt <= '0;
    else if (sw_en) div_cnt <= tick ? '0 : div_cnt + DW'(1);
  end
  // next state from prioritised press events: clr over start over lap
  always_comb begin
    nxt = st;
    if (ev_clr) nxt = IDLE;
    else if (ev_start) nxt = (st == RUN || st == LAP) ? PAUSED : RUN;
    else if (ev_lap) nxt = st == RUN ? LAP : st == LAP ? RUN : st;
  end
  // state register with pause and the clr stretch that lasts through the next tick
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      st    <= IDLE;
      pause <= 1'b1;
      clr   <= 1'b1;
    end else begin
      st    <= nxt;
      pause <= nxt == IDLE || nxt == PAUSED;
      clr   <= ev_clr | (clr & ~tick);
    end
  end
`ifdef STOPWATCH_LAP_EN
  assign ev_lap = press[2] & sw_en;
  // display hold is asserted only while in LAP
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) lap_hold <= 1'b0;
    else lap_hold <= nxt == LAP;
  end
`else
  assign ev_lap   = 1'b0;
  assign lap_hold = 1'b0;
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: scoreboard bench with a cycle-schedule reference model of the stopwatch controller
module tb_stopwatch_ctrl;
  localparam int DB = 4, DIV = 10, N1 = 3000, N2 = 200, NMAX = 3100;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif
  logic CLK = 1'b0, rst_n = 1'b0, key_start = 1'b1, key_clr = 1'b1, key_lap = 1'b1, sw_en = 1'b1;
  logic tick, pause, clr, lap_hold;
  logic [1:0] state;
  bit ks[NMAX], kc[NMAX], kl[NMAX], swv[NMAX];
  bit [2:0] ev[NMAX];
  logic [5:0] expq[$];
  int cycq[$];
  int compared = 0, mismatched = 0;

  stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100), .DB_CYCLES(DB)) dut (
    .CLK(CLK), .rst_n(rst_n), .key_start(key_start), .key_clr(key_clr), .key_lap(key_lap),
    .sw_en(sw_en), .tick(tick), .pause(pause), .clr(clr), .lap_hold(lap_hold), .state(state)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got state=%b pause=%b clr=%b lap_hold=%b tick=%b, expected state=%b pause=%b clr=%b lap_hold=%b tick=%b",
               name, got[5:4], got[3], got[2], got[1], got[0], exp[5:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < NMAX; i++) begin
      ks[i] = 1; kc[i] = 1; kl[i] = 1; swv[i] = 1; ev[i] = '0;
    end
  endtask

  // hold key k low for len cycles from cycle t; a long enough hold is an event seen by the FSM at cycle t+DB+3
  task automatic put(input int k, input int t, input int len);
    for (int i = t; i < t + len && i < NMAX; i++)
      if (k == 0) ks[i] = 0; else if (k == 1) kc[i] = 0; else kl[i] = 0;
    if (len >= DB && t + DB + 3 < NMAX) ev[t + DB + 3][k] = 1'b1;
  endtask

  function automatic logic [1:0] next_state(input logic [1:0] s, input bit st, input bit cl, input bit lp);
    if (cl) return 2'd0;
    if (st) return (s == 2'd1 || s == 2'd3) ? 2'd2 : 2'd1;
    if (lp && s == 2'd1) return 2'd3;
    if (lp && s == 2'd3) return 2'd1;
    return s;
  endfunction

  // apply reset, then drive n cycles of the schedule and queue the expected outputs for each cycle
  task automatic run_session(input int n);
    logic [1:0] s;
    bit cl, tk, acc_s, acc_c, acc_l;
    int en;
    s = 2'd0; cl = 1; tk = 0; en = 0;
    @(posedge CLK); #1;
    key_start = ks[0]; key_clr = kc[0]; key_lap = kl[0]; sw_en = swv[0];
    rst_n = 1'b0;
    #1 check("reset", {state, pause, clr, lap_hold, tick}, 6'b00_1_1_0_0);
    repeat (2) @(posedge CLK);
    #1 rst_n = 1'b1;
    for (int c = 0; c < n; c++) begin
      if (c > 0) begin
        @(posedge CLK); #1;
      end
      key_start = ks[c]; key_clr = kc[c]; key_lap = kl[c]; sw_en = swv[c];
      if (c > 0) begin
        acc_s = swv[c-1] && ev[c][0];
        acc_c = swv[c-1] && ev[c][1];
        acc_l = swv[c-1] && ev[c][2] && LAP_EN;
        s  = next_state(s, acc_s, acc_c, acc_l);
        cl = acc_c || (cl && !tk);
        en += int'(swv[c-1]);
      end
      tk = swv[c] && (en % DIV == DIV - 1);
      expq.push_back({s, s == 2'd0 || s == 2'd2, cl, s == 2'd3, tk});
      cycq.push_back(c);
    end
    @(negedge CLK); #1;
  endtask

  // monitor: every cycle the DUT presents its outputs, pop the oldest expectation and compare
  initial begin
    logic [5:0] e;
    int c;
    forever begin
      @(negedge CLK);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        c = cycq.pop_front();
        check($sformatf("cycle %0d", c), {state, pause, clr, lap_hold, tick}, e);
      end
    end
  end

  // watchdog so a stuck run still reports
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d, required 0", expq.size());
    $fatal(1);
  end

  initial begin
    int t, span;
    clear_stim();
    put(0, 5, 3);
    put(0, 20, 10);
    put(2, 40, 6);
    put(2, 60, 6);
    put(0, 80, 6);
    put(1, 80, 6);
    put(0, 100, 6);
    put(1, 103, 6);
    put(0, 112, 6);
    for (int i = 120; i < 145; i++) swv[i] = 0;
    put(0, 125, 6);
    for (int k = 0; k < 3; k++) begin
      span = k == 1 ? 250 : 40;
      t = 200;
      while (t < N1 - 30) begin
        int len;
        len = ($urandom % 4 == 0) ? 1 + int'($urandom % (DB - 1)) : DB + int'($urandom % 8);
        put(k, t, len);
        t += len + DB + 2 + int'($urandom % span);
      end
    end
    t = 200;
    while (t < N1) begin
      t += 20 + int'($urandom % 150);
      for (int i = t, j = t + 1 + int'($urandom % 30); i < j && i < NMAX; i++) swv[i] = 0;
      t += 31;
    end
    run_session(N1);
    clear_stim();
    for (int i = 0; i < 30; i++) ks[i] = 0;
    put(0, 60, 6);
    put(2, 80, 6);
    put(0, 100, 6);
    put(1, 140, 6);
    run_session(N2);
    compared++;
    if (expq.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left, required 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
